// File: rtl/eth_fcs_pad_axis.sv
// Ethernet FCS stage: zero-pads short frames, appends the IEEE 802.3 CRC-32 and
// re-packs densely onto a 64-bit AXI-Stream master. Errored frames get an inverted FCS.
module eth_fcs_pad_axis #(
   parameter int unsigned MIN_FRAME_BYTES = 60
) (
   input  logic        cclk,
   input  logic        reset_n,
   input  logic [63:0] s_axis_tdata,
   input  logic [7:0]  s_axis_tkeep,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tuser,
   output logic [63:0] m_axis_tdata,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic [31:0] frame_count
);

   typedef enum logic [1:0] {ST_DATA, ST_PAD, ST_FCS} state_t;

   localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
   localparam logic [7:0]  MIN_BYTES = 8'(MIN_FRAME_BYTES);

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      return c;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  pad_left_q, pad_left_d;
   logic [31:0] pend_q, pend_d;
   logic [2:0]  pend_cnt_q, pend_cnt_d;
   logic        err_q, err_d;
   logic [63:0] tdata_q, tdata_d;
   logic [7:0]  tkeep_q, tkeep_d;
   logic        tvalid_q, tvalid_d;
   logic        tlast_q, tlast_d;
   logic        tuser_q, tuser_d;
   logic [31:0] frame_count_q, frame_count_d;

   logic        out_free, accept, lead, fin, fin_err;
   logic [3:0]  nb, room, m;
   logic [63:0] src;
   logic [31:0] crc_steps [0:8];
   logic [8:0]  total;
   logic [7:0]  pad_rem;
   logic [31:0] crc_fin, fcs, fcs_wire;

   always_comb begin
      // NOTE: every _d takes its _q as a default first, so no path leaves a latch behind.
      state_d       = state_q;
      crc_d         = crc_q;
      cnt_d         = cnt_q;
      pad_left_d    = pad_left_q;
      pend_d        = pend_q;
      pend_cnt_d    = pend_cnt_q;
      err_d         = err_q;
      tdata_d       = tdata_q;
      tkeep_d       = tkeep_q;
      tlast_d       = tlast_q;
      tuser_d       = tuser_q;
      tvalid_d      = tvalid_q & ~m_axis_tready;
      frame_count_d = frame_count_q + {31'h0, tvalid_q & m_axis_tready & tlast_q};

      out_free      = ~tvalid_q | m_axis_tready;
      s_axis_tready = reset_n & (state_q == ST_DATA) & out_free;
      accept        = s_axis_tvalid & s_axis_tready;

      nb   = 4'd0;
      lead = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         if (lead && s_axis_tkeep[i]) nb = nb + 4'd1;
         else                         lead = 1'b0;
      end
      if (!s_axis_tlast) nb = 4'd8;

      // Bytes past the last valid one are forced to zero; they double as in-beat pad.
      src = '0;
      if (state_q == ST_DATA)
         for (int i = 0; i < 8; i++)
            if (4'(i) < nb) src[63-8*i -: 8] = s_axis_tdata[63-8*i -: 8];

      crc_steps[0] = crc_q;
      for (int i = 0; i < 8; i++) crc_steps[i+1] = crc_byte(crc_steps[i], src[63-8*i -: 8]);

      total   = {1'b0, cnt_q} + {5'h0, nb};
      pad_rem = (total < {1'b0, MIN_BYTES}) ? (MIN_BYTES - total[7:0]) : 8'h0;
      room    = 4'd8 - nb;
      fin     = 1'b0;
      m       = 4'd8;
      fin_err = 1'b0;

      case (state_q)
         ST_DATA: if (accept) begin
            if (!s_axis_tlast || (pad_rem > {4'h0, room})) begin
               tvalid_d = 1'b1;
               tdata_d  = src;
               tkeep_d  = 8'hFF;
               tlast_d  = 1'b0;
               tuser_d  = 1'b0;
               crc_d    = crc_steps[8];
               cnt_d    = (cnt_q > 8'd247) ? 8'hFF : cnt_q + 8'd8;
               if (s_axis_tlast) begin
                  pad_left_d = pad_rem - {4'h0, room};
                  err_d      = s_axis_tuser;
                  state_d    = ST_PAD;
               end
            end else begin
               fin     = 1'b1;
               m       = nb + pad_rem[3:0];
               fin_err = s_axis_tuser;
            end
         end
         ST_PAD: if (out_free) begin
            if (pad_left_q > 8'd8) begin
               tvalid_d   = 1'b1;
               tdata_d    = '0;
               tkeep_d    = 8'hFF;
               tlast_d    = 1'b0;
               tuser_d    = 1'b0;
               crc_d      = crc_steps[8];
               pad_left_d = pad_left_q - 8'd8;
            end else begin
               fin     = 1'b1;
               m       = pad_left_q[3:0];
               fin_err = err_q;
            end
         end
         ST_FCS: if (out_free) begin
            tvalid_d = 1'b1;
            tdata_d  = {pend_q, 32'h0};
            tkeep_d  = ~(8'hFF >> pend_cnt_q);
            tlast_d  = 1'b1;
            tuser_d  = err_q;
            state_d  = ST_DATA;
         end
         default: state_d = ST_DATA;
      endcase

      // Frame content ends after m bytes of this beat; the FCS starts right there.
      crc_fin  = crc_steps[m];
      fcs      = fin_err ? crc_fin : ~crc_fin;
      fcs_wire = {fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24]};
      if (fin) begin
         tvalid_d = 1'b1;
         tdata_d  = src | ({fcs_wire, 32'h0} >> {m, 3'b000});
         crc_d    = 32'hFFFF_FFFF;
         cnt_d    = 8'h0;
         if (m <= 4'd4) begin
            tkeep_d = ~(8'hFF >> (m + 4'd4));
            tlast_d = 1'b1;
            tuser_d = fin_err;
            state_d = ST_DATA;
         end else begin
            tkeep_d    = 8'hFF;
            tlast_d    = 1'b0;
            tuser_d    = 1'b0;
            pend_d     = fcs_wire << {4'd8 - m, 3'b000};
            pend_cnt_d = 3'(m - 4'd4);
            err_d      = fin_err;
            state_d    = ST_FCS;
         end
      end
   end

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge cclk) begin
      if (!reset_n) begin
         state_q       <= ST_DATA;
         crc_q         <= 32'hFFFF_FFFF;
         cnt_q         <= 8'h0;
         pad_left_q    <= 8'h0;
         pend_q        <= 32'h0;
         pend_cnt_q    <= 3'h0;
         err_q         <= 1'b0;
         tdata_q       <= 64'h0;
         tkeep_q       <= 8'h0;
         tvalid_q      <= 1'b0;
         tlast_q       <= 1'b0;
         tuser_q       <= 1'b0;
         frame_count_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         crc_q         <= crc_d;
         cnt_q         <= cnt_d;
         pad_left_q    <= pad_left_d;
         pend_q        <= pend_d;
         pend_cnt_q    <= pend_cnt_d;
         err_q         <= err_d;
         tdata_q       <= tdata_d;
         tkeep_q       <= tkeep_d;
         tvalid_q      <= tvalid_d;
         tlast_q       <= tlast_d;
         tuser_q       <= tuser_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_eth_fcs_pad_axis.sv
// Scoreboard bench for eth_fcs_pad_axis: a byte-level frame model feeds an expected-beat
// queue, and an independent monitor compares every master handshake against it.
module tb_eth_fcs_pad_axis;

   localparam int MIN = 60;

   logic        cclk = 1'b0;
   logic        reset_n = 1'b0;
   logic [63:0] s_axis_tdata = '0;
   logic [7:0]  s_axis_tkeep = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tuser = 1'b0;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic [31:0] frame_count;

   eth_fcs_pad_axis #(.MIN_FRAME_BYTES(MIN)) dut (
      .cclk(cclk), .reset_n(reset_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .frame_count(frame_count)
   );

   always #5 cclk = ~cclk;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   beat_t exp_q[$];
   int    errors = 0;
   int    checks = 0;
   int    frames_expected = 0;
   bit    abort_mode = 1'b0;
   bit    stall_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference CRC: returns the transmitted FCS value (final XOR applied).
   function automatic logic [31:0] crc32(input logic [7:0] b[$]);
      logic [31:0] c = 32'hFFFF_FFFF;
      foreach (b[k]) begin
         c = c ^ {24'h0, b[k]};
         for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic push_expected(input logic [7:0] d[$], input bit err, output int nbeats);
      logic [7:0]  o[$];
      logic [31:0] fcs;
      o = d;
      while (o.size() < MIN) o.push_back(8'h00);
      fcs = crc32(o);
      if (err) fcs = ~fcs;
      o.push_back(fcs[7:0]);
      o.push_back(fcs[15:8]);
      o.push_back(fcs[23:16]);
      o.push_back(fcs[31:24]);
      nbeats = 0;
      for (int i = 0; i < o.size(); i += 8) begin
         beat_t e;
         int    n;
         n = (o.size() - i < 8) ? o.size() - i : 8;
         e.data = '0;
         for (int j = 0; j < n; j++) e.data[63-8*j -: 8] = o[i+j];
         e.keep = ~(8'hFF >> n);
         e.last = (i + 8 >= o.size());
         e.user = e.last & err;
         exp_q.push_back(e);
         nbeats++;
      end
   endtask

   // Drives one frame; called at posedge+1 and returns at posedge+1.
   task automatic send_frame(input logic [7:0] d[$], input bit err, input bit gap_check);
      int nout, nin, low;
      push_expected(d, err, nout);
      frames_expected++;
      nin = (d.size() == 0) ? 1 : (d.size() + 7) / 8;
      for (int b = 0; b < nin; b++) begin
         int nbytes, t;
         bit last;
         last   = (b == nin - 1);
         nbytes = last ? d.size() - 8*b : 8;
         for (int j = 0; j < 8; j++)
            s_axis_tdata[63-8*j -: 8] = (j < nbytes) ? d[8*b+j] : 8'($urandom);
         if (last)
            s_axis_tkeep = ~(8'hFF >> nbytes) | (8'($urandom) & (8'hFF >> (nbytes + 1)));
         else
            s_axis_tkeep = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         s_axis_tlast  = last;
         s_axis_tuser  = last ? err : 1'($urandom);
         s_axis_tvalid = 1'b1;
         t = 0;
         forever begin
            @(negedge cclk);
            if (s_axis_tready) break;
            if (++t > 2000) begin
               $display("FAIL accept_timeout: got no s_axis_tready expected ready within 2000 cycles");
               $fatal(1);
            end
         end
         @(posedge cclk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (gap_check) begin
         low = 0;
         for (int c = 0; c < 40; c++) begin
            @(negedge cclk);
            if (s_axis_tready) break;
            low++;
         end
         check("ready_low_cycles", 64'(low), 64'(nout - nin));
         @(posedge cclk);
         #1;
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(negedge cclk);
         t++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge cclk);
      check("frame_count", 64'(frame_count), 64'(frames_expected));
      @(posedge cclk);
      #1;
   endtask

   // Downstream ready generator.
   initial forever begin
      @(posedge cclk);
      #1;
      m_axis_tready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   // Monitor: handshakes become visible at negedge and complete at the next posedge.
   initial begin
      bit          prev_stall = 1'b0;
      logic [63:0] prev_data;
      logic [9:0]  prev_ctl;
      forever begin
         @(negedge cclk);
         if (!reset_n) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall) begin
            check("hold_valid", 64'(m_axis_tvalid), 64'd1);
            check("hold_data", m_axis_tdata, prev_data);
            check("hold_ctl", 64'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'(prev_ctl));
         end
         prev_stall = m_axis_tvalid & ~m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_ctl   = {m_axis_tkeep, m_axis_tlast, m_axis_tuser};
         if (m_axis_tvalid && m_axis_tready && !abort_mode) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data %h keep %h expected no beat", m_axis_tdata, m_axis_tkeep);
            end else begin
               beat_t       e;
               logic [63:0] mask;
               e = exp_q.pop_front();
               for (int k = 0; k < 8; k++) mask[63-8*k -: 8] = {8{e.keep[7-k]}};
               check("beat_data", m_axis_tdata & mask, e.data & mask);
               check("beat_ctl", 64'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
                     64'({e.keep, e.last, e.user}));
            end
         end
      end
   end

   initial begin
      logic [7:0] d[$];
      int         dir_len[] = '{42, 68, 69, 0, 8, 52, 56, 59, 60, 61, 63, 64, 72, 125};

      repeat (2) @(posedge cclk);
      @(negedge cclk);
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tlast_tuser", 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
      check("rst_tdata", m_axis_tdata, 64'd0);
      check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
      check("rst_frame_count", 64'(frame_count), 64'd0);
      check("rst_s_tready", 64'(s_axis_tready), 64'd0);
      @(posedge cclk);
      #1;
      reset_n = 1'b1;
      @(posedge cclk);
      #1;

      // "123456789", clean then errored.
      d = {};
      for (int i = 0; i < 9; i++) d.push_back(8'(8'h31 + i));
      send_frame(d, 1'b0, 1'b1);
      send_frame(d, 1'b1, 1'b1);
      foreach (dir_len[n]) begin
         d = {};
         for (int i = 0; i < dir_len[n]; i++) d.push_back(8'(i));
         send_frame(d, (n % 5) == 4, 1'b1);
      end
      drain();

      // Random frames with downstream back-pressure.
      stall_en = 1'b1;
      for (int f = 0; f < 24; f++) begin
         d = {};
         for (int i = 0; i < $urandom_range(0, 130); i++) d.push_back(8'($urandom));
         send_frame(d, $urandom_range(0, 3) == 0, 1'b0);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge cclk);
            #1;
         end
      end
      stall_en = 1'b0;
      drain();

      // Reset during the third beat of a frame.
      abort_mode = 1'b1;
      for (int b = 0; b < 2; b++) begin
         int t = 0;
         s_axis_tdata  = {$urandom, $urandom};
         s_axis_tkeep  = 8'hFF;
         s_axis_tlast  = 1'b0;
         s_axis_tvalid = 1'b1;
         forever begin
            @(negedge cclk);
            if (s_axis_tready || ++t > 100) break;
         end
         @(posedge cclk);
         #1;
      end
      s_axis_tdata = {$urandom, $urandom};
      reset_n      = 1'b0;
      @(negedge cclk);
      check("rst_mid_s_tready", 64'(s_axis_tready), 64'd0);
      @(posedge cclk);
      #1;
      reset_n       = 1'b1;
      s_axis_tvalid = 1'b0;
      @(negedge cclk);
      check("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_mid_frame_count", 64'(frame_count), 64'd0);
      frames_expected = 0;
      @(posedge cclk);
      #1;
      abort_mode = 1'b0;
      d = {};
      for (int i = 0; i < 70; i++) d.push_back(8'($urandom));
      send_frame(d, 1'b0, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
